// File: rtl/port_rate_stats.sv
`default_nettype none
// ============================================================================
// Module   : port_rate_stats
// Purpose  : Per-port byte/packet accumulation with periodic window snapshots.
//            Macro PORT_RATE_STATS_SATURATE_EN selects saturating accumulators.
// Revision : 1.0
// ============================================================================
module port_rate_stats #(
   parameter int NUM_PORTS = 4,
   parameter int PORT_W    = 3,
   parameter int LEN_W     = 16,
   parameter int ACC_W     = 32,
   parameter int WIN_W     = 28
) (
   input  logic                         asclk,
   input  logic                         areset,
   input  logic [WIN_W-1:0]             window_cycles,
   input  logic                         clear,
   input  logic                         stat_valid,
   input  logic [PORT_W-1:0]            stat_port,
   input  logic [LEN_W-1:0]             stat_len,
   output logic [NUM_PORTS*ACC_W-1:0]   byte_total,
   output logic [NUM_PORTS*ACC_W-1:0]   pkt_total,
   output logic [ACC_W-1:0]             drop_total,
   output logic                         snap_valid,
   output logic [15:0]                  window_seq
);

`ifdef PORT_RATE_STATS_SATURATE_EN
   localparam int               SUM_W     = ((ACC_W > LEN_W) ? ACC_W : LEN_W) + 1;
   localparam logic [ACC_W-1:0] c_acc_max = {ACC_W{1'b1}};
`endif

   // Accumulator update: sticks at all-ones or wraps, depending on build.
   function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] acc,
                                               input logic [LEN_W-1:0] inc);
`ifdef PORT_RATE_STATS_SATURATE_EN
      logic [SUM_W-1:0] w_sum;
      w_sum = SUM_W'(acc) + SUM_W'(inc);
      return (w_sum > SUM_W'(c_acc_max)) ? c_acc_max : w_sum[ACC_W-1:0];
`else
      return acc + ACC_W'(inc);
`endif
   endfunction

   logic [WIN_W-1:0] r_wc;
   logic [ACC_W-1:0] r_bytes     [NUM_PORTS];
   logic [ACC_W-1:0] r_pkts      [NUM_PORTS];
   logic [ACC_W-1:0] r_byte_snap [NUM_PORTS];
   logic [ACC_W-1:0] r_pkt_snap  [NUM_PORTS];
   logic [ACC_W-1:0] w_bytes_nxt [NUM_PORTS];
   logic [ACC_W-1:0] w_pkts_nxt  [NUM_PORTS];
   logic [ACC_W-1:0] r_drops;
   logic [ACC_W-1:0] r_drop_snap;
   logic [ACC_W-1:0] w_drops_nxt;
   logic             r_snap_valid;
   logic [15:0]      r_seq;
   logic             w_in_range;
   logic             w_win_end;

   assign w_in_range  = (32'(stat_port) < 32'(NUM_PORTS));
   assign w_drops_nxt = acc_add(r_drops, LEN_W'(stat_valid && !w_in_range));

   // A shrunken window_cycles closes the window at once via the >= compare.
   assign w_win_end = !clear && (window_cycles != '0) && (r_wc >= window_cycles - 1'b1);

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic w_hit;
      assign w_hit          = stat_valid && (32'(stat_port) == 32'(p));
      assign w_bytes_nxt[p] = acc_add(r_bytes[p], w_hit ? stat_len : '0);
      assign w_pkts_nxt[p]  = acc_add(r_pkts[p], LEN_W'(w_hit));
      assign byte_total[p*ACC_W +: ACC_W] = r_byte_snap[p];
      assign pkt_total[p*ACC_W +: ACC_W]  = r_pkt_snap[p];
   end

   always_ff @(posedge asclk) begin
      if (areset || clear || w_win_end) begin
         r_wc    <= '0;
         r_drops <= '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            r_bytes[i] <= '0;
            r_pkts[i]  <= '0;
         end
      end else begin
         r_wc    <= (window_cycles == '0) ? '0 : r_wc + 1'b1;
         r_drops <= w_drops_nxt;
         for (int i = 0; i < NUM_PORTS; i++) begin
            r_bytes[i] <= w_bytes_nxt[i];
            r_pkts[i]  <= w_pkts_nxt[i];
         end
      end
   end

   // Snapshot takes the next-state values so a window-end sample is included.
   always_ff @(posedge asclk) begin
      if (areset) begin
         r_snap_valid <= 1'b0;
         r_seq        <= '0;
         r_drop_snap  <= '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            r_byte_snap[i] <= '0;
            r_pkt_snap[i]  <= '0;
         end
      end else begin
         r_snap_valid <= w_win_end;
         if (w_win_end) begin
            r_seq       <= r_seq + 16'd1;
            r_drop_snap <= w_drops_nxt;
            for (int i = 0; i < NUM_PORTS; i++) begin
               r_byte_snap[i] <= w_bytes_nxt[i];
               r_pkt_snap[i]  <= w_pkts_nxt[i];
            end
         end
      end
   end

   assign drop_total = r_drop_snap;
   assign snap_valid = r_snap_valid;
   assign window_seq = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_port_rate_stats.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_rate_stats
// Purpose  : Directed self-checking bench for port_rate_stats.
// Revision : 1.0
// ============================================================================
module tb_port_rate_stats;

   logic         asclk = 1'b0;
   logic         areset;
   logic [27:0]  window_cycles;
   logic         clear;
   logic         stat_valid;
   logic [2:0]   stat_port;
   logic [15:0]  stat_len;
   logic [127:0] byte_total;
   logic [127:0] pkt_total;
   logic [31:0]  drop_total;
   logic         snap_valid;
   logic [15:0]  window_seq;

   logic [27:0]  win2;
   logic         clear2;
   logic         valid2;
   logic [2:0]   port2;
   logic [15:0]  len2;
   logic [31:0]  byte_total2;
   logic [31:0]  pkt_total2;
   logic [7:0]   drop_total2;
   logic         snap_valid2;
   logic [15:0]  window_seq2;

   int n_tests = 0;
   int n_fail  = 0;
   logic any_snap;
   logic [7:0] exp_sat;

   always #5 asclk = ~asclk;

   port_rate_stats dut (
      .asclk(asclk), .areset(areset), .window_cycles(window_cycles), .clear(clear),
      .stat_valid(stat_valid), .stat_port(stat_port), .stat_len(stat_len),
      .byte_total(byte_total), .pkt_total(pkt_total), .drop_total(drop_total),
      .snap_valid(snap_valid), .window_seq(window_seq)
   );

   port_rate_stats #(.ACC_W(8)) dut8 (
      .asclk(asclk), .areset(areset), .window_cycles(win2), .clear(clear2),
      .stat_valid(valid2), .stat_port(port2), .stat_len(len2),
      .byte_total(byte_total2), .pkt_total(pkt_total2), .drop_total(drop_total2),
      .snap_valid(snap_valid2), .window_seq(window_seq2)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge asclk);
      #1;
   endtask

   task automatic sample(input logic v, input logic [2:0] p, input logic [15:0] l);
      stat_valid = v;
      stat_port  = p;
      stat_len   = l;
   endtask

   initial begin
      areset = 1'b1; window_cycles = 28'd10; clear = 1'b0;
      sample(1'b1, 3'd1, 16'd64);
      win2 = '0; clear2 = 1'b0; valid2 = 1'b0; port2 = 3'd2; len2 = 16'd100;
      repeat (3) tick();
      check("rst_snap_valid", snap_valid, 0);
      check("rst_byte_total", byte_total, 0);
      check("rst_window_seq", window_seq, 0);

      // Window 1: cycles 0..9, port 1 samples on cycles 2, 5, 9
      areset   = 1'b0;
      any_snap = 1'b0;
      for (int c = 0; c < 10; c++) begin
         sample(c == 2 || c == 5 || c == 9, 3'd1, 16'd64);
         tick();
         if (c < 9) any_snap = any_snap | snap_valid;
      end
      check("w1_no_early_snap", any_snap, 0);
      check("w1_snap_valid", snap_valid, 1);
      check("w1_byte_total", byte_total, 128'd192 << 32);
      check("w1_pkt_total", pkt_total, 128'd3 << 32);
      check("w1_drop_total", drop_total, 0);
      check("w1_window_seq", window_seq, 1);

      // Window 2: sample on the window-end cycle 19
      for (int c = 10; c < 20; c++) begin
         sample(c == 19, 3'd0, 16'd100);
         tick();
      end
      sample(1'b0, 3'd0, 16'd0);
      check("w2_snap_valid", snap_valid, 1);
      check("w2_byte_total", byte_total, 128'd100);
      check("w2_pkt_total", pkt_total, 128'd1);
      check("w2_window_seq", window_seq, 2);
      tick();
      check("w2_pulse_one_cycle", snap_valid, 0);
      repeat (9) tick();
      check("w3_snap_valid", snap_valid, 1);
      check("w3_excludes_prev", byte_total, 0);
      check("w3_window_seq", window_seq, 3);

      // Window 4: out-of-range ports plus highest valid port
      for (int c = 30; c < 40; c++) begin
         if (c >= 31 && c <= 33) sample(1'b1, 3'd5, 16'd20);
         else if (c == 35)       sample(1'b1, 3'd3, 16'd7);
         else if (c == 36)       sample(1'b1, 3'd4, 16'd9);
         else                    sample(1'b0, 3'd0, 16'd0);
         tick();
      end
      sample(1'b0, 3'd0, 16'd0);
      check("w4_drop_total", drop_total, 4);
      check("w4_byte_total", byte_total, 128'd7 << 96);
      check("w4_pkt_total", pkt_total, 128'd1 << 96);
      check("w4_window_seq", window_seq, 4);

      // Clear at wc=6 with pending samples and a discarded same-cycle sample
      for (int c = 40; c < 47; c++) begin
         if (c == 41 || c == 43) sample(1'b1, 3'd2, 16'd10);
         else if (c == 46)       sample(1'b1, 3'd2, 16'd99);
         else                    sample(1'b0, 3'd0, 16'd0);
         clear = (c == 46);
         tick();
      end
      clear = 1'b0;
      check("clr_snap_valid", snap_valid, 0);
      check("clr_seq_kept", window_seq, 4);
      check("clr_drop_kept", drop_total, 4);
      any_snap = 1'b0;
      for (int c = 47; c < 57; c++) begin
         sample(c == 50, 3'd2, 16'd5);
         tick();
         if (c < 56) any_snap = any_snap | snap_valid;
      end
      check("clr_no_early_snap", any_snap, 0);
      check("clr_snap_valid_late", snap_valid, 1);
      check("clr_byte_total", byte_total, 128'd5 << 64);
      check("clr_pkt_total", pkt_total, 128'd1 << 64);
      check("clr_drop_total", drop_total, 0);
      check("clr_window_seq", window_seq, 5);

      // Windowing disabled for 50 cycles, then window of 4
      window_cycles = 28'd0;
      any_snap = 1'b0;
      for (int k = 0; k < 50; k++) begin
         sample(1'b1, 3'd0, 16'd1);
         tick();
         any_snap = any_snap | snap_valid;
      end
      check("w0_no_snap", any_snap, 0);
      window_cycles = 28'd4;
      sample(1'b0, 3'd0, 16'd0);
      repeat (3) tick();
      check("w0_to_4_not_yet", snap_valid, 0);
      tick();
      check("w0_to_4_snap_valid", snap_valid, 1);
      check("w0_to_4_byte_total", byte_total, 128'd50);
      check("w0_to_4_pkt_total", pkt_total, 128'd50);
      check("w0_to_4_window_seq", window_seq, 6);

      // window_cycles == 1: snapshot every cycle
      window_cycles = 28'd1;
      sample(1'b1, 3'd1, 16'd3);
      tick();
      sample(1'b0, 3'd0, 16'd0);
      check("w1c_snap_a", snap_valid, 1);
      check("w1c_byte_a", byte_total, 128'd3 << 32);
      check("w1c_seq_a", window_seq, 7);
      tick();
      check("w1c_snap_b", snap_valid, 1);
      check("w1c_byte_b", byte_total, 0);
      check("w1c_seq_b", window_seq, 8);

      // Lower window_cycles below wc+1 mid-window
      window_cycles = 28'd10;
      repeat (5) tick();
      check("shrink_no_snap", snap_valid, 0);
      window_cycles = 28'd3;
      sample(1'b1, 3'd0, 16'd8);
      tick();
      sample(1'b0, 3'd0, 16'd0);
      check("shrink_snap_valid", snap_valid, 1);
      check("shrink_byte_total", byte_total, 128'd8);
      check("shrink_window_seq", window_seq, 9);

      // 8-bit accumulators: 3 x 100 bytes on port 2
`ifdef PORT_RATE_STATS_SATURATE_EN
      exp_sat = 8'd255;
`else
      exp_sat = 8'd44;
`endif
      valid2 = 1'b1;
      repeat (3) tick();
      valid2 = 1'b0;
      win2   = 28'd1;
      tick();
      check("acc8_snap_valid", snap_valid2, 1);
      check("acc8_byte_total", byte_total2[23:16], exp_sat);
      check("acc8_pkt_total", pkt_total2, 32'd3 << 16);

      // Mid-run reset clears snapshots
      areset = 1'b1;
      tick();
      check("rst2_window_seq", window_seq, 0);
      check("rst2_byte_total", byte_total, 0);
      check("rst2_snap_valid", snap_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/port_rate_stats.md
PORT_RATE_STATS -- requirements
Module: port_rate_stats

Interface
REQ-001 SHALL provide parameter NUM_PORTS, default 4, number of tracked ports (1..16).
REQ-002 SHALL provide parameter PORT_W, default 3, width of port index input.
REQ-003 SHALL provide parameter LEN_W, default 16, width of packet length input.
REQ-004 SHALL provide parameter ACC_W, default 32, width of byte and packet accumulators.
REQ-005 SHALL provide parameter WIN_W, default 28, width of window length.
REQ-006 SHALL have port asclk, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port areset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port window_cycles, input, WIN_W, window length in cycles; 0 = windowing disabled.
REQ-009 SHALL have port clear, input, 1, synchronous clear of accumulators and window counter.
REQ-010 SHALL have port stat_valid, input, 1, qualifies one per-packet sample.
REQ-011 SHALL have port stat_port, input, PORT_W, port index of the sample.
REQ-012 SHALL have port stat_len, input, LEN_W, packet length in bytes.
REQ-013 SHALL have port byte_total, output, NUM_PORTS*ACC_W, per-port byte snapshot; port p at [p*ACC_W +: ACC_W].
REQ-014 SHALL have port pkt_total, output, NUM_PORTS*ACC_W, per-port packet snapshot, same packing.
REQ-015 SHALL have port drop_total, output, ACC_W, snapshot count of samples with stat_port >= NUM_PORTS.
REQ-016 SHALL have port snap_valid, output, 1, one-cycle pulse on each snapshot update.
REQ-017 SHALL have port window_seq, output, 16, snapshot sequence number, wraps at 0xFFFF->0.

Function
REQ-018 SHALL keep an internal window counter wc counting 0..window_cycles-1, incrementing every cycle when window_cycles != 0.
REQ-019 SHALL define window end as the cycle where window_cycles != 0 and wc >= window_cycles-1; wc then returns to 0 next cycle.
REQ-020 SHALL, when window_cycles is lowered below wc+1 mid-window, end the window on that cycle (>= compare).
REQ-021 SHALL, on a stat_valid cycle with stat_port < NUM_PORTS, add stat_len (zero-extended) to that port's byte accumulator and 1 to its packet accumulator.
REQ-022 SHALL, on a stat_valid cycle with stat_port >= NUM_PORTS, leave port accumulators unchanged and increment the drop accumulator.
REQ-023 SHALL, at window end, load each snapshot output with its accumulator value including any sample of that same cycle, and zero all accumulators.
REQ-024 SHALL update snapshot outputs on the clock edge closing the window-end cycle; snap_valid is high exactly the following cycle; window_seq increments with each snapshot.
REQ-025 SHALL, with window_cycles == 1, snapshot every cycle (snap_valid continuously high).
REQ-026 SHALL, with window_cycles == 0, hold wc at 0, keep accumulating, never pulse snap_valid.
REQ-027 SHALL, when clear is high, zero accumulators and wc that cycle, discard any same-cycle sample and suppress a same-cycle window end; snapshot outputs and window_seq retained.
REQ-028 SHALL accept one sample per cycle with no backpressure; no sample is lost except under clear.

Reset
REQ-029 SHALL, while areset is high, zero wc, all accumulators, byte_total, pkt_total, drop_total, window_seq and snap_valid.
REQ-030 SHALL ignore stat_valid during reset; the first window starts at wc = 0 on the first cycle after areset deasserts.

Configuration
REQ-031 SHALL honour macro PORT_RATE_STATS_SATURATE_EN: defined -> every accumulator saturates at all-ones (2^ACC_W-1) and holds until window end/clear; undefined -> accumulators wrap modulo 2^ACC_W.

Verification
REQ-032 SHALL check: window_cycles=10, port 1 samples len 64 on cycles 2,5,9 after reset -> snap_valid at cycle 10, byte_total[1]=192, pkt_total[1]=3, others 0, window_seq=1.
REQ-033 SHALL check: sample port 0 len 100 on window-end cycle -> included in closing snapshot; next window byte_total[0] excludes it.
REQ-034 SHALL check: stat_port=5 with NUM_PORTS=4, 3 samples -> drop_total=3, all port totals 0.
REQ-035 SHALL check: ACC_W=8, 3 samples len 100 on port 2 -> byte_total[2]=255 with SATURATE_EN, 44 without.
REQ-036 SHALL check: clear asserted at wc=6 with pending samples, window_cycles=10 -> next snapshot 10 cycles after clear, contains only post-clear samples.
REQ-037 SHALL check: window_cycles=0 for 50 cycles then set to 4 -> no snap_valid while 0, snapshot containing all 50-cycle samples within 4 cycles of change.
